// File: rtl/hello_scroll_ctrl.sv
// Timed select sequencer for the 8-position HELLO scroller: free-running, pausable,
// reversible 3-bit position counter with an extended dwell at position 0.
module hello_scroll_ctrl #(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned HOLD_TICKS = 2
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       clear,
   input  logic       run,
   input  logic       dir,
   input  logic       step,
   output logic [2:0] bits,
   output logic       wrap,
   output logic       busy
);

   localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PresMax  = PW'(TICK_DIV - 1);
   localparam logic [3:0]    HoldInit = 4'(HOLD_TICKS);
   localparam bit            HasDwell = (HOLD_TICKS != 0);

   typedef enum logic [1:0] {StStop, StRun, StDwell} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    dwell_q, dwell_d;
   logic [2:0]    bits_q,  bits_d;
   logic          wrap_q,  wrap_d;
   logic          busy_q,  busy_d;

   logic          tick;
   logic [2:0]    adv;
   logic          adv_zero;

   assign tick     = (presc_q == PresMax);
   assign adv      = dir ? (bits_q - 3'd1) : (bits_q + 3'd1);
   assign adv_zero = (adv == 3'd0);

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= StStop;
         presc_q <= '0;
         dwell_q <= '0;
         bits_q  <= '0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         dwell_q <= dwell_d;
         bits_q  <= bits_d;
         wrap_q  <= wrap_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = StStop;
      end else begin
         unique case (state_q)
            StStop: begin
               if (run) state_d = StRun;
            end
            StRun: begin
               if (!run) state_d = StStop;
               else if (tick && adv_zero && HasDwell) state_d = StDwell;
            end
            StDwell: begin
               if (!run) state_d = StStop;
               else if (tick && (dwell_q == 4'd1)) state_d = StRun;
            end
            default: state_d = StStop;
         endcase
      end
   end

   always_comb begin
      presc_d = presc_q;
      dwell_d = dwell_q;
      bits_d  = bits_q;
      wrap_d  = 1'b0;
      if (clear) begin
         presc_d = '0;
         dwell_d = '0;
         bits_d  = '0;
      end else begin
         unique case (state_q)
            StStop: begin
               presc_d = '0;
               // run has priority: a coincident step is dropped
               if (!run && step) begin
                  bits_d = adv;
                  wrap_d = adv_zero;
               end
            end
            StRun: begin
               if (!run) begin
                  presc_d = '0;
               end else begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
                  if (tick) begin
                     bits_d = adv;
                     wrap_d = adv_zero;
                     if (adv_zero && HasDwell) dwell_d = HoldInit;
                  end
               end
            end
            StDwell: begin
               if (!run) begin
                  presc_d = '0;
                  dwell_d = '0;
               end else begin
                  presc_d = tick ? '0 : presc_q + 1'b1;
                  if (tick) dwell_d = dwell_q - 4'd1;
               end
            end
            default: begin
               presc_d = '0;
               dwell_d = '0;
            end
         endcase
      end
      busy_d = (state_d != StStop);
   end

   assign bits = bits_q;
   assign wrap = wrap_q;
   assign busy = busy_q;

endmodule

// File: doc/hello_scroll_ctrl.md
# hello_scroll_ctrl

Timed sequencer for the 3-bit select of the 8-position HELLO scroller: generates the `bits` select that steps the word across the eight HEX displays at a programmable rate, with a longer dwell at position 0 so the word rests fully visible before scrolling again. Sits between board inputs (switches/keys) and the scroller mux bank. It replaces the static switch-driven select with a free-running, pausable, reversible counter.

## Interface
- `TICK_DIV`, 50_000_000 — clock cycles per scroll step (1 Hz at 50 MHz). Legal range ≥ 2.
- `HOLD_TICKS`, 2 — extra step periods spent at position 0 after each wrap. Legal range 0..15.

Ports:
- `CLOCK_50`  in  1  system clock; all state is on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear. Highest priority after reset.
- `run`  in  1  level. 1 = scroll automatically, 0 = stopped.
- `dir`  in  1  0 = increment `bits` (left shift), 1 = decrement (right shift).
- `step`  in  1  single-cycle pulse. Manual advance of one position, honoured only in STOP.
- `bits`  out  3  registered select to the scroller mux bank.
- `wrap`  out  1  registered one-cycle pulse, high in the cycle in which `bits` first shows 0 after a move.
- `busy`  out  1  registered. 1 when state ≠ STOP.

## Operation
- Reset (`Resetn`=0, asynchronous) sets: state = STOP, `bits`=0, `wrap`=0, `busy`=0, prescaler = 0, dwell counter = 0.
- Prescaler:
  - Width is clog2(`TICK_DIV`).
  - Counts 0..`TICK_DIV`-1 in RUN and DWELL.
  - `tick` is internal and asserted when count = `TICK_DIV`-1; the count then returns to 0.
  - Held at 0 in STOP.
- Advance rule:
  - `bits` ← `bits`+1 mod 8 when `dir`=0, `bits`−1 mod 8 when `dir`=1.
  - `dir` is sampled on the advancing cycle.
  - A wrap is any advance whose result is 0 (7→0 up, or 1→0 down).
- FSM:
  - **STOP**
    - `run`=1 → RUN.
    - Else `step`=1 → apply one advance (no dwell); `wrap` pulses if the result is 0.
    - `run` and `step` together: `run` wins and the step is dropped.
  - **RUN**
    - `run`=0 → STOP. `bits` is retained and the prescaler cleared; a coincident tick is discarded.
    - Else on tick → advance. If the result is 0 and `HOLD_TICKS`>0, go to DWELL with dwell counter = `HOLD_TICKS`.
  - **DWELL**
    - `bits` is frozen at 0.
    - `run`=0 → STOP.
    - Else on tick: decrement the dwell counter; when it reaches 0 → RUN.
    - `step` is ignored.
- `clear`=1 (synchronous, overrides everything except reset): state = STOP, `bits`=0, prescaler = 0, dwell = 0, `wrap`=0. `clear` does not itself pulse `wrap`.
- `wrap` is 0 in every cycle other than the one described above.
- `busy` is registered from the next state.

## Timing
- `run` sampled 1 at edge k: state = RUN and `busy`=1 after edge k.
  - First advance is visible after edge k+`TICK_DIV`.
  - Subsequent advances follow every `TICK_DIV` cycles.
- Step latency: `step` sampled at edge k gives the new `bits` after edge k (one-cycle registered latency).
- Dwell duration: after a wrap, `bits` stays 0 for (`HOLD_TICKS`+1)×`TICK_DIV` cycles before the next advance. With `HOLD_TICKS`=0 there is no DWELL.
- `wrap` is asserted for exactly one cycle, coincident with the first cycle `bits`=0.
- `Resetn` deasserting mid-operation: the block always resumes from STOP/0 and requires `run` again. No recovery of the prior position.
- A `dir` change mid-run takes effect at the next tick only. The prescaler phase is unaffected.

## Test plan
Parameters for all cases: `TICK_DIV`=4, `HOLD_TICKS`=2.

1. **Reset.** Assert `Resetn`=0 asynchronously mid-cycle while running → `bits`=0, `wrap`=0, `busy`=0 immediately. After release with `run`=0, outputs hold for 20 cycles.
2. **Free run up.** Set `run`=1 at edge 0 → `bits` = 1,2,…,7 after edges 4,8,…,28.
   - `bits`=0 with `wrap`=1 after edge 32 (`wrap` high for one cycle only).
   - `bits` holds 0 until edge 44, then becomes 1 after edge 44.
3. **Reverse.** Start from `bits`=2 (via `step` ×2 in STOP), then `dir`=1, `run`=1 → `bits` = 1, then 0 with `wrap` pulse, then dwell 12 cycles, then 7.
4. **Pause/step.** While running at `bits`=3, drop `run` → `busy`=0 next cycle, `bits` stays 3.
   - `step` pulse with `dir`=0 → 4 next cycle.
   - `run` and `step` together → step ignored, `bits` stays 4.
   - The first advance is 4 cycles after entering RUN.
5. **Clear precedence.** `clear`=1 during DWELL and during RUN at `bits`=5, with `run` held 1 → `bits`=0, `wrap`=0, state STOP for that cycle; RUN again the cycle after `clear` drops.
6. **Manual wrap.** In STOP at `bits`=7, `step` with `dir`=0 → `bits`=0, `wrap`=1 for one cycle, state remains STOP (no DWELL).
